// File: rtl/hash_table_pkg.sv
// rtl/hash_table_pkg.sv - shared types for the hash-table front-end sequencer
package hash_table_pkg;

  typedef enum logic [1:0] {
    NOTHING = 2'b00,
    READ    = 2'b01,
    WRITE   = 2'b10,
    DELETE  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    OK        = 2'b00,
    NOT_FOUND = 2'b01,
    FULL      = 2'b10,
    NO_TARGET = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HASH = 3'd1,
    ST_READ = 3'd2,
    ST_WAIT = 3'd3,
    ST_EXEC = 3'd4,
    ST_RESP = 3'd5
  } seq_state_t;

endpackage

// File: rtl/hash_table_sequencer.sv
// rtl/hash_table_sequencer.sv - single-request sequencer in front of the cuckoo hash-table controller
module hash_table_sequencer
  import hash_table_pkg::*;
#(
  parameter int KEY_WIDTH           = 2,
  parameter int DATA_WIDTH          = 32,
  parameter int NUMBER_OF_TABLES    = 3,
  parameter int HASH_TABLE_MAX_SIZE = 2,
  parameter int READ_LATENCY        = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          req_valid_i,
  output logic                                          req_ready_o,
  input  logic [1:0]                                    req_op_i,
  input  logic [KEY_WIDTH-1:0]                          req_key_i,
  input  logic [DATA_WIDTH-1:0]                         req_data_i,
  output logic [KEY_WIDTH-1:0]                          hash_key_o,
  input  logic [NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE-1:0] hash_adr_i,
  output logic                                          mem_rd_en_o,
  output logic [NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE-1:0] mem_rd_adr_o,
  output logic [1:0]                                    ctrl_op_o,
  output logic [KEY_WIDTH-1:0]                          ctrl_key_o,
  output logic [DATA_WIDTH-1:0]                         ctrl_data_o,
  output logic [NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE-1:0] ctrl_hash_adr_o,
  input  logic [DATA_WIDTH-1:0]                         ctrl_read_data_i,
  input  logic                                          no_deletion_target_i,
  input  logic                                          no_write_space_i,
  input  logic                                          no_element_found_i,
  output logic                                          rsp_valid_o,
  input  logic                                          rsp_ready_i,
  output logic [1:0]                                    rsp_op_o,
  output logic [DATA_WIDTH-1:0]                         rsp_data_o,
  output logic [1:0]                                    rsp_status_o
);

  localparam int ADR_W = NUMBER_OF_TABLES * HASH_TABLE_MAX_SIZE;
  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  seq_state_t            state, state_nxt;
  op_t                   op_q;
  logic [KEY_WIDTH-1:0]  key_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADR_W-1:0]      adr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  status_t               rsp_status_q;

  // State register; reset aborts any in-flight request and drops ctrl_op_o at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the per-state strobes
  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    mem_rd_en_o = 1'b0;
    ctrl_op_o   = 2'b00;
    rsp_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = (op_t'(req_op_i) == NOTHING) ? ST_RESP : ST_HASH;
      end
      ST_HASH: state_nxt = ST_READ;
      ST_READ: begin
        mem_rd_en_o = 1'b1;
        state_nxt   = (READ_LATENCY > 1) ? ST_WAIT : ST_EXEC;
      end
      ST_WAIT: if (cnt_q == CNT_W'(1)) state_nxt = ST_EXEC;
      ST_EXEC: begin
        ctrl_op_o = op_q;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Held request, hash addresses, latency counter and response payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= NOTHING;
      key_q        <= '0;
      data_q       <= '0;
      adr_q        <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= OK;
    end else begin
      case (state)
        ST_IDLE: if (req_valid_i) begin
          op_q         <= op_t'(req_op_i);
          key_q        <= req_key_i;
          data_q       <= req_data_i;
          rsp_data_q   <= '0;
          rsp_status_q <= OK;
        end
        ST_HASH: adr_q <= hash_adr_i;
        ST_READ: cnt_q <= CNT_W'(READ_LATENCY - 1);
        ST_WAIT: cnt_q <= cnt_q - CNT_W'(1);
        ST_EXEC: begin
          // Only the flag belonging to the current op can fail it
          case (op_q)
            READ: begin
              if (no_element_found_i) rsp_status_q <= NOT_FOUND;
              else                    rsp_data_q   <= ctrl_read_data_i;
            end
            WRITE:   if (no_write_space_i)     rsp_status_q <= FULL;
            DELETE:  if (no_deletion_target_i) rsp_status_q <= NO_TARGET;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign hash_key_o      = key_q;
  assign mem_rd_adr_o    = adr_q;
  assign ctrl_key_o      = key_q;
  assign ctrl_data_o     = data_q;
  assign ctrl_hash_adr_o = adr_q;
  assign rsp_op_o        = op_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_status_o    = rsp_status_q;

endmodule

// File: tb/tb_hash_table_sequencer.sv
// tb/tb_hash_table_sequencer.sv - directed scoreboard bench for hash_table_sequencer
module tb_hash_table_sequencer;
  import hash_table_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel, req_valid, rsp_ready;
  logic [1:0]  req_op, req_key;
  logic [31:0] req_data, rd_data;
  logic        nf, nws, ndt;

  logic        req_valid_a, req_valid_b;
  logic        req_ready_a, req_ready_b, rd_en_a, rd_en_b, rsp_valid_a, rsp_valid_b;
  logic [1:0]  hash_key_a, hash_key_b, ctrl_op_a, ctrl_op_b, ctrl_key_a, ctrl_key_b;
  logic [1:0]  rsp_op_a, rsp_op_b, rsp_status_a, rsp_status_b;
  logic [5:0]  hash_adr_a, hash_adr_b, rd_adr_a, rd_adr_b, ctrl_adr_a, ctrl_adr_b;
  logic [31:0] ctrl_data_a, ctrl_data_b, rsp_data_a, rsp_data_b;

  function automatic logic [5:0] hash_of(input logic [1:0] k);
    return {~k, k + 2'd1, k};
  endfunction

  assign hash_adr_a  = hash_of(hash_key_a);
  assign hash_adr_b  = hash_of(hash_key_b);
  assign req_valid_a = req_valid & ~sel;
  assign req_valid_b = req_valid & sel;

  hash_table_sequencer #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
    .req_op_i(req_op), .req_key_i(req_key), .req_data_i(req_data),
    .hash_key_o(hash_key_a), .hash_adr_i(hash_adr_a),
    .mem_rd_en_o(rd_en_a), .mem_rd_adr_o(rd_adr_a),
    .ctrl_op_o(ctrl_op_a), .ctrl_key_o(ctrl_key_a), .ctrl_data_o(ctrl_data_a),
    .ctrl_hash_adr_o(ctrl_adr_a), .ctrl_read_data_i(rd_data),
    .no_deletion_target_i(ndt), .no_write_space_i(nws), .no_element_found_i(nf),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready), .rsp_op_o(rsp_op_a),
    .rsp_data_o(rsp_data_a), .rsp_status_o(rsp_status_a));

  hash_table_sequencer #(.READ_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
    .req_op_i(req_op), .req_key_i(req_key), .req_data_i(req_data),
    .hash_key_o(hash_key_b), .hash_adr_i(hash_adr_b),
    .mem_rd_en_o(rd_en_b), .mem_rd_adr_o(rd_adr_b),
    .ctrl_op_o(ctrl_op_b), .ctrl_key_o(ctrl_key_b), .ctrl_data_o(ctrl_data_b),
    .ctrl_hash_adr_o(ctrl_adr_b), .ctrl_read_data_i(rd_data),
    .no_deletion_target_i(ndt), .no_write_space_i(nws), .no_element_found_i(nf),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready), .rsp_op_o(rsp_op_b),
    .rsp_data_o(rsp_data_b), .rsp_status_o(rsp_status_b));

  wire        o_req_ready  = sel ? req_ready_b  : req_ready_a;
  wire [1:0]  o_hash_key   = sel ? hash_key_b   : hash_key_a;
  wire        o_rd_en      = sel ? rd_en_b      : rd_en_a;
  wire [5:0]  o_rd_adr     = sel ? rd_adr_b     : rd_adr_a;
  wire [1:0]  o_ctrl_op    = sel ? ctrl_op_b    : ctrl_op_a;
  wire [1:0]  o_ctrl_key   = sel ? ctrl_key_b   : ctrl_key_a;
  wire [31:0] o_ctrl_data  = sel ? ctrl_data_b  : ctrl_data_a;
  wire [5:0]  o_ctrl_adr   = sel ? ctrl_adr_b   : ctrl_adr_a;
  wire        o_rsp_valid  = sel ? rsp_valid_b  : rsp_valid_a;
  wire [1:0]  o_rsp_op     = sel ? rsp_op_b     : rsp_op_a;
  wire [31:0] o_rsp_data   = sel ? rsp_data_b   : rsp_data_a;
  wire [1:0]  o_rsp_status = sel ? rsp_status_b : rsp_status_a;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [1:0]  status;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // One request end to end: handshake, timing of strobes, optional back-pressure, scoreboard pop
  task automatic do_req(input logic s, input logic [1:0] op, input logic [1:0] key,
                        input logic [31:0] data, input logic [31:0] rdata,
                        input logic f_nf, input logic f_nws, input logic f_ndt,
                        input logic [1:0] est, input logic [31:0] edata, input int hold);
    int   rl, t_rd, t_exec, n_exec, t_rsp;
    exp_t e;
    sel = s;
    rl  = s ? 3 : 1;
    rd_data = rdata; nf = f_nf; nws = f_nws; ndt = f_ndt;
    rsp_ready = (hold == 0);
    chk("req_ready_idle", 32'(o_req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_key = key; req_data = data;
    sb.push_back('{op: op, data: edata, status: est});
    cyc();
    req_valid = 1'b0;
    t_rd = 0; t_exec = 0; n_exec = 0; t_rsp = 0;
    for (int t = 1; t <= 20 && t_rsp == 0; t++) begin
      if (o_rd_en) begin
        t_rd = t;
        chk("rd_adr", 32'(o_rd_adr), 32'(hash_of(key)));
        chk("hash_key", 32'(o_hash_key), 32'(key));
      end
      if (o_ctrl_op != 2'b00) begin
        n_exec++;
        t_exec = t;
        chk("ctrl_op", 32'(o_ctrl_op), 32'(op));
        chk("ctrl_key", 32'(o_ctrl_key), 32'(key));
        chk("ctrl_data", o_ctrl_data, data);
        chk("ctrl_adr", 32'(o_ctrl_adr), 32'(hash_of(key)));
      end
      if (o_rsp_valid) t_rsp = t;
      else begin
        chk("req_ready_busy", 32'(o_req_ready), 32'd0);
        cyc();
      end
    end
    if (op == 2'b00) begin
      chk("nop_rd_en_cycle", 32'(t_rd), 32'd0);
      chk("nop_exec_count", 32'(n_exec), 32'd0);
      chk("nop_rsp_cycle", 32'(t_rsp), 32'd1);
    end else begin
      chk("rd_en_cycle", 32'(t_rd), 32'd2);
      chk("exec_count", 32'(n_exec), 32'd1);
      chk("exec_cycle", 32'(t_exec), 32'(2 + rl));
      chk("rsp_cycle", 32'(t_rsp), 32'(3 + rl));
    end
    if (t_rsp == 0) begin
      void'(sb.pop_back());
      return;
    end
    e = sb[0];
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(o_rsp_valid), 32'd1);
      chk("hold_data", o_rsp_data, e.data);
      chk("hold_status", 32'(o_rsp_status), 32'(e.status));
      chk("hold_req_ready", 32'(o_req_ready), 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    e = sb.pop_front();
    chk("rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("rsp_op", 32'(o_rsp_op), 32'(e.op));
    chk("rsp_data", o_rsp_data, e.data);
    chk("rsp_status", 32'(o_rsp_status), 32'(e.status));
    cyc();
    chk("rsp_valid_drop", 32'(o_rsp_valid), 32'd0);
    chk("req_ready_back", 32'(o_req_ready), 32'd1);
    if (op != 2'b00) chk("rd_adr_held", 32'(o_rd_adr), 32'(hash_of(key)));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 2'b00; req_key = 2'b00; req_data = '0; rd_data = '0;
    nf = 1'b0; nws = 1'b0; ndt = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_req_ready", 32'(o_req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("rst_rd_en", 32'(o_rd_en), 32'd0);
      chk("rst_ctrl_op", 32'(o_ctrl_op), 32'd0);
      chk("rst_rsp_data", o_rsp_data, 32'd0);
      chk("rst_rd_adr", 32'(o_rd_adr), 32'd0);
    end
    sel = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Reset in the middle of EXEC
    req_valid = 1'b1; req_op = 2'b10; req_key = 2'b11; req_data = 32'h1234_5678;
    cyc();
    req_valid = 1'b0;
    n = 0;
    while (o_ctrl_op == 2'b00 && n < 10) begin cyc(); n++; end
    chk("reach_exec", 32'(o_ctrl_op), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("rst_exec_ctrl_op", 32'(o_ctrl_op), 32'd0);
    chk("rst_exec_rsp_valid", 32'(o_rsp_valid), 32'd0);
    #3;
    rst_n = 1'b1;
    cyc();
    chk("rst_exec_req_ready", 32'(o_req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("rst_exec_no_rsp", 32'(o_rsp_valid), 32'd0);
      cyc();
    end

    // READ_LATENCY=1 instance
    do_req(1'b0, 2'b10, 2'b01, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        0);
    do_req(1'b0, 2'b01, 2'b01, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF, 0);
    do_req(1'b0, 2'b01, 2'b10, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0,        0);
    do_req(1'b0, 2'b10, 2'b11, 32'hCAFE0001, 32'h0,        1'b1, 1'b1, 1'b1, 2'b10, 32'h0,        0);
    do_req(1'b0, 2'b10, 2'b10, 32'hCAFE0002, 32'h0,        1'b1, 1'b0, 1'b1, 2'b00, 32'h0,        0);
    do_req(1'b0, 2'b11, 2'b10, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 2'b11, 32'h0,        0);
    do_req(1'b0, 2'b11, 2'b01, 32'h0,        32'h5555AAAA, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        2);
    do_req(1'b0, 2'b00, 2'b00, 32'h0,        32'hFFFF0000, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0,        0);

    // READ_LATENCY=3 instance with response back-pressure
    do_req(1'b1, 2'b10, 2'b01, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        5);
    do_req(1'b1, 2'b01, 2'b01, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 2'b00, 32'hA5A5A5A5, 5);
    do_req(1'b1, 2'b00, 2'b10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
